// File: rtl/seq_mul_pkg.sv
// Shared types and defaults for the sequential-multiplier request driver.
package seq_mul_pkg;

  localparam int DEF_DW         = 4;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_TO_CYC     = 32;

  // Driver FSM encoding: IDLE waits for a queued pair, REQ holds the
  // request level until ack, RSP holds the product until it is taken.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } drv_state_t;

  // Product (and packed operand pair) width for a given operand width.
  function automatic int prod_w(input int dw);
    return 2 * dw;
  endfunction

endpackage

// File: rtl/seq_mul_fifo.sv
// Synchronous operand FIFO: push/pop in one cycle, full/empty flags and an
// occupancy count. Pushes while full and pops while empty are dropped.
module seq_mul_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];
  assign level    = count;

  // Storage write; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (!do_push && do_pop) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_mul_drv.sv
// Request driver for the sequential multiplier: queues operand pairs,
// issues them one at a time on req/ack, and returns products in order.
// Optional watchdog on the REQ wait: define SEQ_MUL_DRV_TIMEOUT_EN.
//
// Handshakes:
//   in_*  / out_* : a beat transfers on a rising edge where valid & ready
//                   are both 1; the source holds data stable while valid=1
//                   and ready=0.
//   req / ack     : req is a level held with req_data stable until the
//                   multiplier returns a one-cycle ack pulse carrying the
//                   product on ack_data; ack while not in REQ is ignored.
module seq_mul_drv
  import seq_mul_pkg::*;
#(
  parameter int DW         = DEF_DW,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
`ifdef SEQ_MUL_DRV_TIMEOUT_EN
  ,
  parameter int TO_CYC     = DEF_TO_CYC
`endif
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DW-1:0]                 in_op1,
  input  logic [DW-1:0]                 in_op2,
  output logic                          req,
  output logic [prod_w(DW)-1:0]         req_data,
  input  logic                          ack,
  input  logic [prod_w(DW)-1:0]         ack_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [prod_w(DW)-1:0]         out_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy,
  output logic                          err,
  output drv_state_t                    dbg_state
);

  localparam int PW = prod_w(DW);

  drv_state_t    state_q;
  drv_state_t    state_d;
  logic [PW-1:0] fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;
  logic          head_vld_q;
  logic          take_ack;
  logic          to_abort;
  logic          to_hit;

  seq_mul_fifo #(
    .W     (PW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_valid & in_ready),
    .push_data ({in_op1, in_op2}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign in_ready  = ~fifo_full;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

`ifdef SEQ_MUL_DRV_TIMEOUT_EN
  localparam int TCW = ($clog2(TO_CYC) > 8) ? $clog2(TO_CYC) : 8;

  logic [TCW-1:0] to_cnt;
  logic           err_q;

  // Watchdog: restart on every new request, count REQ cycles, pulse err on abort.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= to_abort;
      if (fifo_pop) begin
        to_cnt <= '0;
      end else if (state_q == ST_REQ) begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  assign to_hit = (to_cnt == TCW'(TO_CYC - 1));
  assign err    = err_q;
`else
  assign to_hit = 1'b0;
  assign err    = 1'b0;
`endif

  // Next-state and one-cycle control strobes; ack beats the watchdog.
  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    take_ack = 1'b0;
    to_abort = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (head_vld_q && !fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        if (ack) begin
          take_ack = 1'b1;
          state_d  = ST_RSP;
        end else if (to_hit) begin
          to_abort = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      ST_RSP: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs. head_vld_q stages the FIFO non-empty flag
  // by one cycle so a request always launches from a settled head entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      head_vld_q <= 1'b0;
      req        <= 1'b0;
      req_data   <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
    end else begin
      state_q    <= state_d;
      head_vld_q <= ~fifo_empty;
      if (fifo_pop) begin
        req      <= 1'b1;
        req_data <= fifo_head;
      end
      if (take_ack) begin
        req       <= 1'b0;
        out_valid <= 1'b1;
        out_data  <= ack_data;
      end
      if (to_abort) begin
        req <= 1'b0;
      end
      if ((state_q == ST_RSP) && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_mul_drv.sv
// Directed bench for seq_mul_drv with a behavioural multiplier responder,
// an in-order scoreboard for requests and products, and hand-computed vectors.
module tb_seq_mul_drv;
  import seq_mul_pkg::*;

  localparam int DW = 4;
  localparam int PW = 8;
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_op1;
  logic [DW-1:0] in_op2;
  logic          req;
  logic [PW-1:0] req_data;
  logic          ack;
  logic [PW-1:0] ack_data;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_data;
  logic [LW-1:0] fifo_level;
  logic          busy;
  logic          err;
  drv_state_t    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  int ack_delay = 2;
  bit ack_en    = 1'b1;
  bit stray     = 1'b0;
  int age       = 0;
  logic [PW-1:0] ma;
  logic [PW-1:0] mb;

  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] req_exp_q[$];

  seq_mul_drv #(
    .DW         (DW),
    .FIFO_DEPTH (4)
`ifdef SEQ_MUL_DRV_TIMEOUT_EN
    ,
    .TO_CYC     (8)
`endif
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op1     (in_op1),
    .in_op2     (in_op2),
    .req        (req),
    .req_data   (req_data),
    .ack        (ack),
    .ack_data   (ack_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .fifo_level (fifo_level),
    .busy       (busy),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / global bound ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "bench time limit");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Push on the very next edge; caller knows there is room.
  task automatic push_now(input logic [3:0] a, input logic [3:0] b, input logic [7:0] p, input bit has_prod);
    in_valid = 1'b1;
    in_op1   = a;
    in_op2   = b;
    req_exp_q.push_back({a, b});
    if (has_prod) exp_q.push_back(p);
    check("push_now_ready", in_ready, 1);
    tick(1);
  endtask

  // Hold valid until the FIFO accepts; in_valid is left high for the caller.
  task automatic push_wait(input logic [3:0] a, input logic [3:0] b, input logic [7:0] p);
    in_valid = 1'b1;
    in_op1   = a;
    in_op2   = b;
    req_exp_q.push_back({a, b});
    exp_q.push_back(p);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (!in_ready) check("push_accept", in_ready, 1);
    tick(1);
  endtask

  task automatic wait_out(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    if (!out_valid) check("out_wait", out_valid, 1);
    tick(1);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && req_exp_q.size() == 0 && !out_valid) break;
    end
    check("drain_products_left", exp_q.size(), 0);
    check("drain_requests_left", req_exp_q.size(), 0);
    tick(1);
  endtask

  // Called with req already high: returns the number of cycles it stays high.
  task automatic req_len(output int n);
    n = 1;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (req) n++;
      else break;
    end
  endtask

  // ---------------- multiplier responder ----------------
  initial begin
    ack      = 1'b0;
    ack_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!req) age = 0;
      else age = age + 1;
      ack = 1'b0;
      if (stray) begin
        ack      = 1'b1;
        ack_data = 8'hAA;
        stray    = 1'b0;
      end else if (ack_en && req && age == ack_delay) begin
        ma       = {4'b0, req_data[7:4]};
        mb       = {4'b0, req_data[3:0]};
        ack      = 1'b1;
        ack_data = ma * mb;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  logic prev_req  = 1'b0;
  int   low_cnt   = 0;
  bit   gap_armed = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (req) begin
        if (req_exp_q.size() > 0) check("req_data", req_data, req_exp_q[0]);
        else check("req_spurious", req, 0);
        if (!prev_req) begin
          if (gap_armed) check("req_gap_ge2", (low_cnt >= 2), 1);
          gap_armed = 1'b0;
          low_cnt   = 0;
        end
        if (ack) gap_armed = 1'b1;
      end else begin
        low_cnt++;
        if (prev_req && req_exp_q.size() > 0) void'(req_exp_q.pop_front());
      end
      if (out_valid) begin
        if (exp_q.size() > 0) begin
          check("out_data", out_data, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end else begin
          check("out_spurious", out_valid, 0);
        end
      end
      prev_req = req;
    end
  end

  // ---------------- directed sequence ----------------
  int n;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op1    = '0;
    in_op2    = '0;
    out_ready = 1'b0;
    tick(3);

    // Reset values
    check("rst_req", req, 0);
    check("rst_req_data", req_data, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_level", fifo_level, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_state", dbg_state, ST_IDLE);
    rst_n = 1'b1;
    tick(2);

    // Single op 3*5, ack 6 cycles into req; req rises two edges after push
    out_ready = 1'b1;
    ack_delay = 6;
    push_now(4'd3, 4'd5, 8'd15, 1'b1);
    in_valid = 1'b0;
    check("t1_level_after_push", fifo_level, 1);
    check("t1_req_k0", req, 0);
    tick(1);
    check("t1_req_k1", req, 0);
    tick(1);
    check("t1_req_k2", req, 1);
    check("t1_req_data", req_data, 8'h35);
    check("t1_busy", busy, 1);
    check("t1_state_req", dbg_state, ST_REQ);
    check("t1_level_popped", fifo_level, 0);
    req_len(n);
    check("t1_req_len", n, 6);
    check("t1_out_valid", out_valid, 1);
    check("t1_out_data", out_data, 8'd15);
    check("t1_state_rsp", dbg_state, ST_RSP);
    tick(1);
    check("t1_out_taken", out_valid, 0);
    check("t1_idle", busy, 0);

    // ack in the first req cycle: 10*13
    ack_delay = 1;
    push_now(4'd10, 4'd13, 8'd130, 1'b1);
    in_valid = 1'b0;
    tick(2);
    check("ta_req", req, 1);
    req_len(n);
    check("ta_req_len", n, 1);
    check("ta_out_valid", out_valid, 1);
    check("ta_out_data", out_data, 8'd130);
    tick(1);

    // Push and pop on the same edge leave the level unchanged
    ack_delay = 3;
    push_now(4'd5, 4'd5, 8'd25, 1'b1);
    check("tc_level1", fifo_level, 1);
    push_now(4'd9, 4'd3, 8'd27, 1'b1);
    check("tc_level2", fifo_level, 2);
    push_now(4'd7, 4'd8, 8'd56, 1'b1);
    in_valid = 1'b0;
    check("tc_level_push_pop", fifo_level, 2);
    check("tc_req", req, 1);
    drain(200);

    // Backpressure, fill to full, refill after the stall releases
    out_ready = 1'b0;
    ack_delay = 2;
    push_wait(4'd2, 4'd7, 8'd14);
    in_valid = 1'b0;
    wait_out(50);
    push_wait(4'd0, 4'd9, 8'd0);
    push_wait(4'd15, 4'd15, 8'd225);
    push_wait(4'd1, 4'd1, 8'd1);
    push_wait(4'd6, 4'd9, 8'd54);
    check("tb_level_full", fifo_level, 4);
    check("tb_in_ready_full", in_ready, 0);
    in_op1 = 4'd12;
    in_op2 = 4'd11;
    tick(3);
    check("tb_level_no_overflow", fifo_level, 4);
    check("tb_in_ready_held", in_ready, 0);
    check("tb_req_stalled", req, 0);
    check("tb_out_valid_held", out_valid, 1);
    check("tb_out_data_held", out_data, 8'd14);
    check("tb_busy", busy, 1);
    tick(5);
    out_ready = 1'b1;
    push_wait(4'd12, 4'd11, 8'd132);
    in_valid = 1'b0;
    check("tb_level_refill", fifo_level, 4);
    check("tb_in_ready_refill", in_ready, 0);
    drain(400);
    check("tb_err", err, 0);

    // Reset in REQ with three queued, then a stray ack
    ack_en = 1'b0;
    push_now(4'd3, 4'd3, 8'd9, 1'b1);
    push_now(4'd4, 4'd4, 8'd16, 1'b1);
    push_now(4'd5, 4'd5, 8'd25, 1'b1);
    push_now(4'd6, 4'd6, 8'd36, 1'b1);
    in_valid = 1'b0;
    check("td_req", req, 1);
    check("td_level3", fifo_level, 3);
    check("td_req_data", req_data, 8'h33);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    exp_q.delete();
    req_exp_q.delete();
    check("td_req_after_rst", req, 0);
    check("td_level_after_rst", fifo_level, 0);
    check("td_out_valid_after_rst", out_valid, 0);
    check("td_busy_after_rst", busy, 0);
    check("td_in_ready_after_rst", in_ready, 1);
    stray = 1'b1;
    tick(6);
    check("td_stray_out_valid", out_valid, 0);
    check("td_stray_req", req, 0);
    check("td_stray_level", fifo_level, 0);
    check("td_stray_state", dbg_state, ST_IDLE);
    ack_en = 1'b1;

`ifdef SEQ_MUL_DRV_TIMEOUT_EN
    // Watchdog abort on the first pair, normal completion on the second
    ack_en = 1'b0;
    push_now(4'd2, 4'd3, 8'd0, 1'b0);
    push_now(4'd4, 4'd5, 8'd20, 1'b1);
    in_valid = 1'b0;
    tick(1);
    check("to_req", req, 1);
    req_len(n);
    check("to_req_len", n, 8);
    check("to_err_pulse", err, 1);
    check("to_no_product", out_valid, 0);
    ack_en    = 1'b1;
    ack_delay = 2;
    tick(1);
    check("to_err_cleared", err, 0);
    drain(200);
`endif

    check("final_err", err, 0);
    check("final_idle", busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
